// File: rtl/j_mmult_seq_pkg.sv
// ---------------------------------------------------------------------------
// j_mmult_seq_pkg
// Shared definitions for the Jerry DSP MMULT sequencer:
//   - FSM state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   - default matrix RAM address width and minimum matrix width
//   - MTXC register field positions (width [3:0], column mode bit 4)
//   - helpers for width clamping and counter load-value encoding
// ---------------------------------------------------------------------------
package j_mmult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int AW_DEF   = 11;
  localparam int MINW_DEF = 3;

  // MTXC register image layout
  localparam int MTXC_BITS    = 5;
  localparam int MTXC_W_LSB   = 0;
  localparam int MTXC_W_MSB   = 3;
  localparam int MTXC_COL_BIT = 4;

  // Element counter value whose step wraps the counter to zero
  localparam logic [5:0] CNT_LAST = 6'h3F;

  // Widths below the legal minimum are raised to the minimum.
  function automatic logic [3:0] clamp_width(input logic [3:0] w, input int minw);
    if (int'(w) < minw) begin
      return 4'(minw);
    end
    return w;
  endfunction

  // The counter loads {mr1, 1'b0}; mr1 = -w mod 32 makes it start at 64-2w
  // so that it wraps to zero exactly after 2w element steps.
  function automatic logic [4:0] load_value(input logic [3:0] w);
    return 5'd0 - {1'b0, w};
  endfunction

endpackage

// File: rtl/j_mmult_addr.sv
// ---------------------------------------------------------------------------
// j_mmult_addr
// Matrix RAM read-address generator for the MMULT sequencer. Latches the
// stride when an operation is accepted (1 in row mode, width in column
// mode), loads the base address, and advances by the stride on each step.
// The address wraps modulo 2^AW.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   latch_i  in   operation accepted: capture stride
//   col_i    in   address-by-column mode
//   width_i  in   clamped matrix width
//   load_i   in   load base address
//   base_i   in   base address (longwords)
//   step_i   in   advance address by stride
//   addr_o   out  current read address
// ---------------------------------------------------------------------------
module j_mmult_addr
  import j_mmult_seq_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          latch_i,
  input  logic          col_i,
  input  logic [3:0]    width_i,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o
);

  logic [3:0]    stride_q, stride_d;
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    stride_d = stride_q;
    if (latch_i) begin
      stride_d = col_i ? width_i : 4'd1;
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (step_i) begin
      // Natural overflow of the AW-bit sum gives the modulo wrap.
      addr_d = addr_q + AW'(stride_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride_q <= '0;
      addr_q   <= '0;
    end else begin
      stride_q <= stride_d;
      addr_q   <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/j_mmult_seq.sv
// ---------------------------------------------------------------------------
// j_mmult_seq
// Jerry DSP MMULT sequencer. Sits directly upstream of the 6-bit systolic
// element counter: loads it with -2w (cntld/mr1), steps it once per 16-bit
// element read (cnten), and watches its count to find the end of the row or
// column. Also issues matrix RAM reads, accumulator controls and a one-cycle
// done pulse for result write-back.
//
// Optional feature: define J_MMULT_STALLCNT_EN to add the stall_cnt port, an
// 8-bit saturating count of RUN cycles spent waiting for read data.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle MMULT issue pulse
//   abort      in   cancel current operation
//   mtx_width  in   MTXC matrix width (elements)
//   mtx_col    in   MTXC address-by-column mode
//   mtx_base   in   MTXA base address (longwords)
//   count      in   element counter value
//   rd_ack     in   matrix RAM read data valid
//   cntld      out  counter load strobe
//   cnten      out  counter step enable
//   mr1        out  counter load value (count[5:1])
//   mtx_rd     out  matrix RAM read request
//   mtx_addr   out  matrix RAM read address
//   half_sel   out  source register half select (count[0])
//   acc_clr    out  first accumulate step
//   acc_en     out  accumulate step
//   busy       out  operation in progress
//   done       out  completion pulse
//   stall_cnt  out  stall-cycle counter (J_MMULT_STALLCNT_EN only)
// ---------------------------------------------------------------------------
module j_mmult_seq
  import j_mmult_seq_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int MINW = MINW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    mtx_width,
  input  logic          mtx_col,
  input  logic [AW-1:0] mtx_base,
  input  logic [5:0]    count,
  input  logic          rd_ack,
  output logic          cntld,
  output logic          cnten,
  output logic [4:0]    mr1,
  output logic          mtx_rd,
  output logic [AW-1:0] mtx_addr,
  output logic          half_sel,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          busy,
  output logic          done
`ifdef J_MMULT_STALLCNT_EN
  ,
  output logic [7:0]    stall_cnt
`endif
);

  state_e state_q, state_d;
  logic [3:0] w_q, w_d;
  logic       first_q, first_d;

  logic [MTXC_BITS-1:0] mtxc;
  logic [3:0] width_in;
  logic       col_in;
  logic       accept;
  logic       step;
  logic       last;

  // Reassemble the MTXC register image so field positions live in one place.
  assign mtxc     = {mtx_col, mtx_width};
  assign width_in = clamp_width(mtxc[MTXC_W_MSB:MTXC_W_LSB], MINW);
  assign col_in   = mtxc[MTXC_COL_BIT];

  // abort beats start in IDLE
  assign accept = (state_q == ST_IDLE) && start && !abort;
  // One element step per acknowledged read; abort suppresses the step.
  assign step   = (state_q == ST_RUN) && rd_ack && !abort;
  assign last   = step && (count == CNT_LAST);

  // State register and latched operation parameters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      first_q <= first_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    first_d = first_q;
    if (accept) begin
      w_d = width_in;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        first_d = 1'b1;
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (step) first_d = 1'b0;
        if (abort)     state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cntld   = 1'b0;
    mr1     = '0;
    mtx_rd  = 1'b0;
    cnten   = 1'b0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        cntld = 1'b1;
        mr1   = load_value(w_q);
        busy  = 1'b1;
      end
      ST_RUN: begin
        busy    = 1'b1;
        mtx_rd  = 1'b1;
        cnten   = step;
        acc_en  = step;
        acc_clr = step && first_q;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = !abort;
      end
      default: ;
    endcase
  end

  assign half_sel = count[0];

  j_mmult_addr #(
    .AW (AW)
  ) u_addr (
    .clk     (clk),
    .reset   (reset),
    .latch_i (accept),
    .col_i   (col_in),
    .width_i (width_in),
    .load_i  (state_q == ST_LOAD),
    .base_i  (mtx_base),
    .step_i  (step),
    .addr_o  (mtx_addr)
  );

`ifdef J_MMULT_STALLCNT_EN
  logic [7:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_LOAD) begin
      stall_d = '0;
    end else if ((state_q == ST_RUN) && !rd_ack && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_j_mmult_seq.sv
// ---------------------------------------------------------------------------
// tb_j_mmult_seq
// Directed bench for the MMULT sequencer. A behavioural model of the
// downstream 6-bit element counter closes the loop on cntld/mr1/cnten.
// ---------------------------------------------------------------------------
module tb_j_mmult_seq;

  localparam int AW = 11;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [3:0]    mtx_width;
  logic          mtx_col;
  logic [AW-1:0] mtx_base;
  logic [5:0]    count;
  logic          rd_ack;
  logic          cntld;
  logic          cnten;
  logic [4:0]    mr1;
  logic          mtx_rd;
  logic [AW-1:0] mtx_addr;
  logic          half_sel;
  logic          acc_clr;
  logic          acc_en;
  logic          busy;
  logic          done;
`ifdef J_MMULT_STALLCNT_EN
  logic [7:0]    stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int cnten_n = 0;
  int busy_n  = 0;
  int done_n  = 0;

  j_mmult_seq #(
    .AW   (AW),
    .MINW (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mtx_width (mtx_width),
    .mtx_col   (mtx_col),
    .mtx_base  (mtx_base),
    .count     (count),
    .rd_ack    (rd_ack),
    .cntld     (cntld),
    .cnten     (cnten),
    .mr1       (mr1),
    .mtx_rd    (mtx_rd),
    .mtx_addr  (mtx_addr),
    .half_sel  (half_sel),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .busy      (busy),
    .done      (done)
`ifdef J_MMULT_STALLCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream element counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (cntld) count <= {mr1, 1'b0};
    else if (cnten) count <= count + 6'd1;
  end

  // Event monitors
  always @(posedge clk) begin
    if (cnten) cnten_n <= cnten_n + 1;
    if (busy)  busy_n  <= busy_n + 1;
    if (done)  done_n  <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation. Expected element addresses are base + k*stride
  // (mod 2^AW); stride, mr1 and step count are supplied by the caller.
  task automatic do_op(input logic [3:0] w, input logic c, input logic [AW-1:0] base,
                       input bit stall, input bit restart_mid,
                       input int exp_mr1, input int exp_steps, input int exp_stride);
    int k;
    int cyc;
    int c0, b0, d0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; mtx_width = w; mtx_col = c; mtx_base = base; rd_ack = 1'b1;
    #1;
    chk("idle_busy", 32'(busy), 0);
    c0 = cnten_n; b0 = busy_n; d0 = done_n;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("load_cntld", 32'(cntld), 1);
    chk("load_mr1", 32'(mr1), 32'(exp_mr1));
    chk("load_cnten", 32'(cnten), 0);
    chk("load_busy", 32'(busy), 1);
    k = 0;
    cyc = 0;
    while (k < exp_steps && cyc < 100) begin
      @(negedge clk);
      rd_ack = stall ? (cyc % 2 == 1) : 1'b1;
      if (restart_mid && cyc == 2) begin
        start = 1'b1; mtx_width = 4'd15; mtx_col = 1'b1; mtx_base = '0;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("run_rd", 32'(mtx_rd), 1);
      chk("run_addr", 32'(mtx_addr), 32'((int'(base) + k * exp_stride) % (1 << AW)));
      chk("run_count", 32'(count), 32'((64 - exp_steps + k) % 64));
      chk("run_half", 32'(half_sel), 32'(k % 2));
      chk("run_cnten", 32'(cnten), 32'(rd_ack));
      chk("run_acc_en", 32'(acc_en), 32'(rd_ack));
      chk("run_acc_clr", 32'(acc_clr), 32'(rd_ack && k == 0));
      chk("run_cntld", 32'(cntld), 0);
      if (rd_ack) k++;
      cyc++;
    end
    chk("steps_done", 32'(k), 32'(exp_steps));
    @(negedge clk);
    start = 1'b0; rd_ack = 1'b1;
    #1;
    chk("done_pulse", 32'(done), 1);
    chk("done_rd", 32'(mtx_rd), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_wrap", 32'(count), 0);
`ifdef J_MMULT_STALLCNT_EN
    if (stall) chk("stall_cnt", 32'(stall_cnt), 32'(exp_steps));
`endif
    @(negedge clk);
    #1;
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    chk("cnten_total", 32'(cnten_n - c0), 32'(exp_steps));
    chk("busy_total", 32'(busy_n - b0), 32'(cyc + 2));
    chk("done_total", 32'(done_n - d0), 1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mtx_width = '0; mtx_col = 1'b0;
    mtx_base = '0; rd_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(mtx_addr), 0);
    chk("rst_cntld", 32'(cntld), 0);
    chk("rst_rd", 32'(mtx_rd), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // w=4 row, base 0x100, no stalls: 8 steps, 10 busy cycles
    do_op(4'd4, 1'b0, 11'h100, 1'b0, 1'b0, 'h1C, 8, 1);

    // w=3 column, base 0x7FE: 7FE, 001, 004, 007, 00A, 00D
    do_op(4'd3, 1'b1, 11'h7FE, 1'b0, 1'b0, 'h1D, 6, 3);

    // w=4 row, every other RUN cycle stalled: 8 steps over 16 cycles
    do_op(4'd4, 1'b0, 11'h020, 1'b1, 1'b0, 'h1C, 8, 1);

    // width 1 clamps to 3; a start in mid-RUN is ignored
    do_op(4'd1, 1'b0, 11'h040, 1'b0, 1'b1, 'h1D, 6, 1);

    // abort on the third RUN cycle
    d0 = done_n;
    @(negedge clk);
    start = 1'b1; mtx_width = 4'd4; mtx_col = 1'b0; mtx_base = 11'h200; rd_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_r1_addr", 32'(mtx_addr), 'h200);
    @(negedge clk);
    #1;
    chk("abort_r2_addr", 32'(mtx_addr), 'h201);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_cnten", 32'(cnten), 0);
    chk("abort_acc_en", 32'(acc_en), 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_n - d0), 0);
    do_op(4'd4, 1'b0, 11'h200, 1'b0, 1'b0, 'h1C, 8, 1);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_idle", 32'(busy), 0);
    chk("start_abort_cntld", 32'(cntld), 0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; mtx_width = 4'd4; mtx_col = 1'b0; mtx_base = 11'h300; rd_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rd", 32'(mtx_rd), 0);
    chk("arst_cnten", 32'(cnten), 0);
    chk("arst_acc_en", 32'(acc_en), 0);
    chk("arst_addr", 32'(mtx_addr), 0);
    chk("arst_half", 32'(half_sel), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_cntld", 32'(cntld), 0);
    do_op(4'd5, 1'b0, 11'h300, 1'b0, 1'b0, 'h1B, 10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
